// File: rtl/d_kes_elu_sequencer_if.sv
// rtl/d_kes_elu_sequencer_if.sv - control/data bundle between KES top, PE_DC/PE_ELU arrays and the ELU sequencer
// master drives the requests and discrepancy, slave is the sequencer itself.
interface d_kes_elu_sequencer_if #(
  parameter int GF_ORDER = 12,
  parameter int ITER_W   = 5
);
  logic                i_stop_dec;
  logic                i_start;
  logic [GF_ORDER-1:0] i_d_2i;
  logic                i_d_2i_valid;
  logic                o_EXECUTE_PE_DC;
  logic                o_EXECUTE_PE_ELU;
  logic [GF_ORDER-1:0] o_d_2i;
  logic [GF_ORDER-1:0] o_delta_2im2;
  logic                o_condition_2i;
  logic [ITER_W-1:0]   o_iter_cnt;
  logic                o_busy;
  logic                o_done;
  logic                o_timeout;

  modport master (
    output i_stop_dec, i_start, i_d_2i, i_d_2i_valid,
    input  o_EXECUTE_PE_DC, o_EXECUTE_PE_ELU, o_d_2i, o_delta_2im2, o_condition_2i,
    input  o_iter_cnt, o_busy, o_done, o_timeout
  );

  modport slave (
    input  i_stop_dec, i_start, i_d_2i, i_d_2i_valid,
    output o_EXECUTE_PE_DC, o_EXECUTE_PE_ELU, o_d_2i, o_delta_2im2, o_condition_2i,
    output o_iter_cnt, o_busy, o_done, o_timeout
  );
endinterface

// File: rtl/d_kes_elu_sequencer.sv
// rtl/d_kes_elu_sequencer.sv - inversion-less BM error-locator update iteration sequencer
// Optional WAIT_DC watchdog enabled by defining D_KES_ELU_SEQ_TIMEOUT_EN.
module d_kes_elu_sequencer #(
  parameter int GF_ORDER = 12,
  parameter int T        = 27,
  parameter int ITER_W   = 5,
  parameter int K_W      = 7
`ifdef D_KES_ELU_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT  = 63
`endif
) (
  input logic                  i_clk,
  input logic                  i_RESET_KES,
  d_kes_elu_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, REQ_DC, WAIT_DC, EXEC, GAP, DONE} state_t;

  state_t                state_q, state_d;
  logic [GF_ORDER-1:0]   d_2i_q;
  logic [GF_ORDER-1:0]   delta_q;
  logic signed [K_W-1:0] k_q;
  logic [ITER_W-1:0]     iter_q;
  logic                  abort;
  logic                  condition;
  logic                  timeout_hit;
  logic                  timeout_q;

  assign abort     = i_RESET_KES | bus.i_stop_dec;
  assign condition = (d_2i_q != '0) && !k_q[K_W-1];

`ifdef D_KES_ELU_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] wait_cnt_q;

  // Counter is zero on WAIT_DC entry, so the TIMEOUT-th silent cycle is count TIMEOUT-1.
  assign timeout_hit = (state_q == WAIT_DC) && !bus.i_d_2i_valid &&
                       (wait_cnt_q == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (abort) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= (state_q == WAIT_DC) ? wait_cnt_q + TMO_W'(1) : '0;
      if (timeout_hit)
        timeout_q <= 1'b1;
      else if (state_q == IDLE && bus.i_start)
        timeout_q <= 1'b0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_q   = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (abort) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.i_start) state_d = REQ_DC;
      REQ_DC:  state_d = WAIT_DC;
      WAIT_DC: begin
        if (bus.i_d_2i_valid) state_d = EXEC;
        else if (timeout_hit) state_d = IDLE;
      end
      EXEC:    state_d = GAP;
      // The PE sits in its output state during GAP, so no new request is issued here.
      GAP:     state_d = (iter_q == ITER_W'(T)) ? DONE : REQ_DC;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (abort) begin
      d_2i_q  <= '0;
      delta_q <= GF_ORDER'(1);
      k_q     <= '0;
      iter_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.i_start) begin
          delta_q <= GF_ORDER'(1);
          k_q     <= '0;
          iter_q  <= '0;
        end
        WAIT_DC: if (bus.i_d_2i_valid) d_2i_q <= bus.i_d_2i;
        EXEC: begin
          if (condition) begin
            delta_q <= d_2i_q;
            k_q     <= -k_q - K_W'(1);
          end else begin
            k_q     <= k_q + K_W'(1);
          end
          iter_q <= iter_q + ITER_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.o_EXECUTE_PE_DC  = (state_q == REQ_DC);
    bus.o_EXECUTE_PE_ELU = (state_q == EXEC);
    bus.o_busy           = (state_q != IDLE);
    bus.o_done           = (state_q == DONE);
    bus.o_d_2i           = d_2i_q;
    bus.o_delta_2im2     = delta_q;
    bus.o_condition_2i   = condition;
    bus.o_iter_cnt       = iter_q;
    bus.o_timeout        = timeout_q;
  end
endmodule

// File: tb/tb_d_kes_elu_sequencer.sv
// tb/tb_d_kes_elu_sequencer.sv - directed self-checking bench for d_kes_elu_sequencer
// Cycle 0 is the cycle in which i_start is driven; outputs are sampled on the falling edge.
module tb_d_kes_elu_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic stray_valid = 1'b0;
  logic [11:0] stray_d = 12'h000;
  logic resp_valid = 1'b0;
  logic [11:0] resp_d = 12'h000;
  logic resp_en = 1'b0;
  int resp_cnt = 0;
  int resp_delay = 1;
  logic [11:0] d_tab [0:31];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  d_kes_elu_sequencer_if #(.GF_ORDER(12), .ITER_W(5)) bus ();

  assign bus.i_start      = start;
  assign bus.i_stop_dec   = stop;
  assign bus.i_d_2i_valid = resp_valid | stray_valid;
  assign bus.i_d_2i       = stray_valid ? stray_d : resp_d;

  d_kes_elu_sequencer dut (
    .i_clk       (clk),
    .i_RESET_KES (rst),
    .bus         (bus)
  );

  // PE_DC stand-in: answers each request resp_delay cycles later with d_tab[current iteration].
  always @(negedge clk) begin
    resp_valid = 1'b0;
    if (!resp_en) resp_cnt = 0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        resp_valid = 1'b1;
        resp_d     = d_tab[bus.o_iter_cnt];
      end
    end
    if (resp_en && bus.o_EXECUTE_PE_DC) resp_cnt = resp_delay;
  end

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; resp_en = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
    n_checks++; if (bus.o_EXECUTE_PE_DC !== 1'b0) begin n_fail++; $display("FAIL reset_dc: got %b want 0", bus.o_EXECUTE_PE_DC); end
    n_checks++; if (bus.o_EXECUTE_PE_ELU !== 1'b0) begin n_fail++; $display("FAIL reset_elu: got %b want 0", bus.o_EXECUTE_PE_ELU); end
    n_checks++; if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.o_done); end
    n_checks++; if (bus.o_d_2i !== 12'h000) begin n_fail++; $display("FAIL reset_d: got %h want 000", bus.o_d_2i); end
    n_checks++; if (bus.o_delta_2im2 !== 12'h001) begin n_fail++; $display("FAIL reset_delta: got %h want 001", bus.o_delta_2im2); end
    n_checks++; if (bus.o_iter_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_iter: got %0d want 0", bus.o_iter_cnt); end
    n_checks++; if (bus.o_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", bus.o_timeout); end
    n_checks++; if (bus.o_condition_2i !== 1'b0) begin n_fail++; $display("FAIL reset_cond: got %b want 0", bus.o_condition_2i); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int cyc = 0;
    int n_elu = 0;
    for (int i = 0; i < 32; i++) d_tab[i] = 12'h000;
    d_tab[0] = 12'h5A3;
    resp_delay = 1; resp_en = 1'b1;
    start = 1'b1;
    while (n_elu < 3 && cyc < 50) begin
      @(negedge clk); cyc++; start = 1'b0;
      if (bus.o_EXECUTE_PE_ELU) n_elu++;
    end
    n_checks++; if (cyc !== 11) begin n_fail++; $display("FAIL midrst_third_exec_cycle: got %0d want 11", cyc); end
    n_checks++; if (bus.o_iter_cnt !== 5'd2) begin n_fail++; $display("FAIL midrst_iter_before: got %0d want 2", bus.o_iter_cnt); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", bus.o_busy); end
    n_checks++; if (bus.o_delta_2im2 !== 12'h001) begin n_fail++; $display("FAIL midrst_delta: got %h want 001", bus.o_delta_2im2); end
    n_checks++; if ($signed(dut.k_q) !== 7'sd0) begin n_fail++; $display("FAIL midrst_k: got %0d want 0", $signed(dut.k_q)); end
    n_checks++; if (bus.o_iter_cnt !== 5'd0) begin n_fail++; $display("FAIL midrst_iter: got %0d want 0", bus.o_iter_cnt); end
    n_checks++; if (bus.o_d_2i !== 12'h000) begin n_fail++; $display("FAIL midrst_d: got %h want 000", bus.o_d_2i); end
    for (int i = 0; i < 6; i++) begin
      n_checks++; if ((bus.o_EXECUTE_PE_ELU | bus.o_EXECUTE_PE_DC | bus.o_done) !== 1'b0) begin
        n_fail++; $display("FAIL midrst_strobe: got dc=%b elu=%b done=%b want all 0", bus.o_EXECUTE_PE_DC, bus.o_EXECUTE_PE_ELU, bus.o_done);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_all_zero();
    int cyc = 0;
    int n_elu = 0;
    int last = -1;
    int done_at = -1;
    for (int i = 0; i < 32; i++) d_tab[i] = 12'h000;
    resp_delay = 1; resp_en = 1'b1;
    start = 1'b1;
    while (done_at < 0 && cyc < 300) begin
      @(negedge clk); cyc++; start = 1'b0;
      if (bus.o_EXECUTE_PE_ELU) begin
        n_checks++; if (bus.o_condition_2i !== 1'b0) begin n_fail++; $display("FAIL zero_cond iter %0d: got %b want 0", n_elu, bus.o_condition_2i); end
        n_checks++; if (bus.o_delta_2im2 !== 12'h001) begin n_fail++; $display("FAIL zero_delta iter %0d: got %h want 001", n_elu, bus.o_delta_2im2); end
        if (n_elu == 0) begin
          n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL zero_first_elu: got cycle %0d want 3", cyc); end
        end else begin
          n_checks++; if (cyc - last !== 4) begin n_fail++; $display("FAIL zero_elu_spacing: got %0d want 4", cyc - last); end
        end
        last = cyc; n_elu++;
      end
      if (bus.o_done) done_at = cyc;
    end
    n_checks++; if (n_elu !== 27) begin n_fail++; $display("FAIL zero_elu_count: got %0d want 27", n_elu); end
    n_checks++; if (done_at !== 109) begin n_fail++; $display("FAIL zero_done_cycle: got %0d want 109", done_at); end
    n_checks++; if (bus.o_iter_cnt !== 5'd27) begin n_fail++; $display("FAIL zero_iter_end: got %0d want 27", bus.o_iter_cnt); end
    n_checks++; if ($signed(dut.k_q) !== 7'sd27) begin n_fail++; $display("FAIL zero_k_end: got %0d want 27", $signed(dut.k_q)); end
    @(negedge clk);
    n_checks++; if ({bus.o_busy, bus.o_done} !== 2'b00) begin n_fail++; $display("FAIL zero_after_done: got busy/done=%b want 00", {bus.o_busy, bus.o_done}); end
  endtask

  task automatic test_condition();
    int cyc = 0;
    int n_elu = 0;
    int done_at = -1;
    int mk = 0;
    logic [11:0] mdelta = 12'h001;
    logic exp_cond;
    for (int i = 0; i < 32; i++) d_tab[i] = 12'h000;
    d_tab[0] = 12'h5A3;
    resp_delay = 1; resp_en = 1'b1;
    start = 1'b1;
    while (done_at < 0 && cyc < 300) begin
      @(negedge clk); cyc++; start = 1'b0;
      if (bus.o_EXECUTE_PE_ELU) begin
        exp_cond = (d_tab[n_elu] != 12'h000) && (mk >= 0);
        n_checks++; if (bus.o_d_2i !== d_tab[n_elu]) begin n_fail++; $display("FAIL cond_d iter %0d: got %h want %h", n_elu, bus.o_d_2i, d_tab[n_elu]); end
        n_checks++; if (bus.o_condition_2i !== exp_cond) begin n_fail++; $display("FAIL cond_flag iter %0d: got %b want %b", n_elu, bus.o_condition_2i, exp_cond); end
        n_checks++; if (bus.o_delta_2im2 !== mdelta) begin n_fail++; $display("FAIL cond_delta iter %0d: got %h want %h", n_elu, bus.o_delta_2im2, mdelta); end
        if (n_elu == 1) begin
          n_checks++; if (bus.o_delta_2im2 !== 12'h5A3) begin n_fail++; $display("FAIL cond_delta_iter1: got %h want 5a3", bus.o_delta_2im2); end
          n_checks++; if ($signed(dut.k_q) !== -7'sd1) begin n_fail++; $display("FAIL cond_k_iter1: got %0d want -1", $signed(dut.k_q)); end
        end
        if (exp_cond) begin mdelta = d_tab[n_elu]; mk = -mk - 1; end
        else mk = mk + 1;
        n_elu++;
      end
      if (bus.o_done) done_at = cyc;
    end
    n_checks++; if (done_at !== 109) begin n_fail++; $display("FAIL cond_done_cycle: got %0d want 109", done_at); end
    n_checks++; if ($signed(dut.k_q) !== 7'sd25) begin n_fail++; $display("FAIL cond_k_end: got %0d want 25", $signed(dut.k_q)); end
    n_checks++; if (bus.o_delta_2im2 !== 12'h5A3) begin n_fail++; $display("FAIL cond_delta_end: got %h want 5a3", bus.o_delta_2im2); end
    @(negedge clk);
  endtask

  task automatic test_delayed_stray();
    int cyc = 0;
    int n_elu = 0;
    int last = -1;
    int done_at = -1;
    int mk = 0;
    logic [11:0] mdelta = 12'h001;
    logic exp_cond;
    logic gap_next = 1'b0;
    for (int i = 0; i < 32; i++) d_tab[i] = (i % 3 == 0) ? 12'h000 : 12'h100 + 12'(i);
    resp_delay = 10; resp_en = 1'b1;
    stray_d = 12'hFFF;
    stray_valid = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL stray_idle_busy: got %b want 0", bus.o_busy); end
    stray_valid = 1'b0;
    start = 1'b1;
    while (done_at < 0 && cyc < 500) begin
      @(negedge clk); cyc++;
      start = (cyc == 5 || cyc == 100);
      stray_valid = gap_next; gap_next = 1'b0;
      if (bus.o_EXECUTE_PE_ELU) begin
        exp_cond = (d_tab[n_elu] != 12'h000) && (mk >= 0);
        n_checks++; if (bus.o_d_2i !== d_tab[n_elu]) begin n_fail++; $display("FAIL delay_d iter %0d: got %h want %h", n_elu, bus.o_d_2i, d_tab[n_elu]); end
        n_checks++; if (bus.o_condition_2i !== exp_cond) begin n_fail++; $display("FAIL delay_cond iter %0d: got %b want %b", n_elu, bus.o_condition_2i, exp_cond); end
        n_checks++; if (bus.o_delta_2im2 !== mdelta) begin n_fail++; $display("FAIL delay_delta iter %0d: got %h want %h", n_elu, bus.o_delta_2im2, mdelta); end
        if (n_elu == 0) begin
          n_checks++; if (cyc !== 12) begin n_fail++; $display("FAIL delay_first_elu: got cycle %0d want 12", cyc); end
        end else begin
          n_checks++; if (cyc - last !== 13) begin n_fail++; $display("FAIL delay_elu_spacing: got %0d want 13", cyc - last); end
        end
        if (exp_cond) begin mdelta = d_tab[n_elu]; mk = -mk - 1; end
        else mk = mk + 1;
        last = cyc; n_elu++; gap_next = 1'b1;
      end
      if (bus.o_done) done_at = cyc;
    end
    stray_valid = 1'b0;
    n_checks++; if (n_elu !== 27) begin n_fail++; $display("FAIL delay_elu_count: got %0d want 27", n_elu); end
    n_checks++; if (done_at !== 352) begin n_fail++; $display("FAIL delay_done_cycle: got %0d want 352", done_at); end
    stray_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if ({bus.o_busy, bus.o_EXECUTE_PE_ELU} !== 2'b00) begin n_fail++; $display("FAIL stray_after_done: got busy/elu=%b want 00", {bus.o_busy, bus.o_EXECUTE_PE_ELU}); end
    end
    stray_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stop_restart();
    int cyc = 0;
    int n_elu = 0;
    int done_at = -1;
    for (int i = 0; i < 32; i++) d_tab[i] = 12'h000;
    d_tab[0] = 12'h123;
    resp_delay = 1; resp_en = 1'b1;
    start = 1'b1;
    while (cyc < 10) begin
      @(negedge clk); cyc++; start = 1'b0;
    end
    n_checks++; if ({bus.o_busy, bus.o_EXECUTE_PE_DC, bus.o_EXECUTE_PE_ELU} !== 3'b100) begin n_fail++; $display("FAIL stop_wait_state: got busy/dc/elu=%b want 100", {bus.o_busy, bus.o_EXECUTE_PE_DC, bus.o_EXECUTE_PE_ELU}); end
    n_checks++; if (bus.o_delta_2im2 !== 12'h123) begin n_fail++; $display("FAIL stop_delta_before: got %h want 123", bus.o_delta_2im2); end
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy: got %b want 0", bus.o_busy); end
    n_checks++; if (bus.o_iter_cnt !== 5'd0) begin n_fail++; $display("FAIL stop_iter: got %0d want 0", bus.o_iter_cnt); end
    n_checks++; if (bus.o_delta_2im2 !== 12'h001) begin n_fail++; $display("FAIL stop_delta: got %h want 001", bus.o_delta_2im2); end
    start = 1'b1; cyc = 0;
    while (done_at < 0 && cyc < 300) begin
      @(negedge clk); cyc++; start = 1'b0;
      if (bus.o_EXECUTE_PE_ELU) begin
        if (n_elu == 0) begin
          n_checks++; if (bus.o_delta_2im2 !== 12'h001) begin n_fail++; $display("FAIL restart_delta0: got %h want 001", bus.o_delta_2im2); end
          n_checks++; if (bus.o_condition_2i !== 1'b1) begin n_fail++; $display("FAIL restart_cond0: got %b want 1", bus.o_condition_2i); end
        end
        n_elu++;
      end
      if (bus.o_done) done_at = cyc;
    end
    n_checks++; if (n_elu !== 27) begin n_fail++; $display("FAIL restart_elu_count: got %0d want 27", n_elu); end
    n_checks++; if (done_at !== 109) begin n_fail++; $display("FAIL restart_done_cycle: got %0d want 109", done_at); end
    @(negedge clk);
  endtask

`ifdef D_KES_ELU_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int cyc = 0;
    int idle_at = -1;
    logic saw_done = 1'b0;
    resp_en = 1'b0;
    start = 1'b1;
    while (idle_at < 0 && cyc < 200) begin
      @(negedge clk); cyc++; start = 1'b0;
      if (bus.o_done) saw_done = 1'b1;
      if (!bus.o_busy) idle_at = cyc;
    end
    n_checks++; if (idle_at !== 65) begin n_fail++; $display("FAIL tmo_idle_cycle: got %0d want 65", idle_at); end
    n_checks++; if (bus.o_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: got %b want 1", bus.o_timeout); end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL tmo_done: got %b want 0", saw_done); end
    @(negedge clk);
    n_checks++; if (bus.o_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", bus.o_timeout); end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_checks++; if (bus.o_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got %b want 0", bus.o_timeout); end
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_mid_reset();
    test_all_zero();
    test_condition();
    test_delayed_stray();
    test_stop_restart();
`ifdef D_KES_ELU_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
